id_ex_pipe_reg: RTL
===================

# id_ex_pipe_reg

Parametrised ID→EX pipeline register for the five-stage processor, placed between the decode stage and the execute stage. Captures decoded control bits, register specifiers, operand data and the sign-extended immediate each clock. Also provides hazard control (stall/hold, flush/bubble), a per-entry valid bit, and two saturating event counters (stall cycles, bubbles inserted) for pipeline performance monitoring.

## Interface
Parameters:
- DATA_W, 32, operand and immediate width
- REG_ADDR_W, 5, register-specifier width
- ALU_CTRL_W, 4, ALU control field width
- CNT_W, 16, width of each event counter
- BUBBLE_ON_STALL, 0, stall mode: 0 = hold contents; 1 = inject bubble (load-use style, ID held upstream)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hold request from hazard unit
- flush_i  in  1  bubble request (branch/jump redirect)
- clr_cnt_i  in  1  synchronous clear of both counters
- valid_d  in  1  ID stage holds a real instruction
- reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d  in  1 each  decoded control
- alu_ctrl_d  in  ALU_CTRL_W  ALU operation
- rs_d, rt_d, rd_d  in  REG_ADDR_W  register specifiers
- data1_d, data2_d, imm_d  in  DATA_W  register-file reads, sign-extended immediate
- valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e  out  1 each  registered copies
- alu_ctrl_e  out  ALU_CTRL_W; rs_e, rt_e, rd_e  out  REG_ADDR_W; data1_e, data2_e, imm_e  out  DATA_W
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- rst is asynchronous and active-high. While it is asserted, every output is 0, including both counters.
- Each rising edge performs exactly one action, chosen by priority:
  1. flush_i=1 → bubble: all _e fields 0, valid_e=0.
  2. stall_i=1, BUBBLE_ON_STALL=0 → hold: every _e output keeps its value.
  3. stall_i=1, BUBBLE_ON_STALL=1 → bubble, same as flush.
  4. Otherwise → load: every _e output takes its _d input; valid_e=valid_d.
- A bubble zeroes all fields, datapath included. A bubble therefore never writes the register file or memory.
- If valid_d=0 on a load, the control bits are still captured as presented. ID must already present zero control bits for an invalid instruction; this block does not mask them.
- stall_cnt_o increments on each edge where stall_i=1 and flush_i=0.
- flush_cnt_o increments on each edge where a bubble is actually inserted, by either flush or stall-bubble mode.
- Both counters saturate at 2^CNT_W−1; there is no wrap-around.
- clr_cnt_i=1 forces both counters to 0 on that edge, overriding any increment that edge.

## Timing
- Latency is 1 cycle: _d values sampled at edge N appear on _e after edge N.
- There are no combinational paths from inputs to outputs.
- Hold: contents stay stable for as long as stall_i stays high. When stall_i drops, the value present on _d at that edge is loaded.
- flush_i and stall_i both high: flush wins. stall_cnt_o does not count that cycle; flush_cnt_o does.
- rst asserted mid-operation clears outputs immediately, without waiting for a clock edge. The first load happens on the first edge after rst is released.
- Counter at saturation with an increment condition: holds at all-ones.

## Structure
- Shared package id_ex_pkg holds:
  - a packed struct id_ex_ctrl_t: reg_write, mem_to_reg, mem_write, alu_src, reg_dst, alu_ctrl;
  - a constant ID_EX_CTRL_NOP (all zero), used for bubbles;
  - default width constants for DATA_W, REG_ADDR_W, ALU_CTRL_W.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, count), instantiated twice.
- Pipeline fields live in a single always block with asynchronous reset.

## Test plan
- Reset then load: assert rst, then release. Apply valid_d=1, reg_write_d=1, alu_ctrl_d=4'h2, rs_d=5'd3, data1_d=32'hDEADBEEF, imm_d=32'hFFFF_FFFC. After one edge the _e outputs equal these values; valid_e=1.
- Hold, BUBBLE_ON_STALL=0: load data1_d=32'h11, then hold stall_i=1 for 3 edges while data1_d=32'h22. data1_e stays 32'h11 and stall_cnt_o=3. Drop stall_i; the next edge gives data1_e=32'h22.
- Flush: after a valid load with mem_write_d=1, pulse flush_i for one edge. valid_e=0, mem_write_e=0, all data outputs 0, flush_cnt_o=1.
- Simultaneous: stall_i=1 and flush_i=1 on the same edge. The result is a bubble; stall_cnt_o is unchanged and flush_cnt_o increments by 1.
- Stall-bubble mode plus saturation: with BUBBLE_ON_STALL=1 and CNT_W=3, hold stall_i=1 for 10 edges. valid_e=0 throughout, and both counters read 3'd7. Assert clr_cnt_i for one edge; both counters read 0.
- Asynchronous reset mid-hold: assert rst between edges while stalled. All outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the ID->EX pipeline register.
package id_ex_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALU_CTRL_W = 4;

  // Decoded control bundle carried from ID into EX.
  typedef struct packed {
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      mem_write;
    logic                      alu_src;
    logic                      reg_dst;
    logic [DEF_ALU_CTRL_W-1:0] alu_ctrl;
  } id_ex_ctrl_t;

  // All-zero control word: a bubble that writes neither the register file nor memory.
  localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with hold/bubble hazard control and event counters.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int ALU_CTRL_W      = DEF_ALU_CTRL_W,
  parameter int CNT_W           = 16,
  parameter int BUBBLE_ON_STALL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  clr_cnt_i,
  input  logic                  valid_d,
  input  logic                  reg_write_d,
  input  logic                  mem_to_reg_d,
  input  logic                  mem_write_d,
  input  logic                  alu_src_d,
  input  logic                  reg_dst_d,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [DATA_W-1:0]     data1_d,
  input  logic [DATA_W-1:0]     data2_d,
  input  logic [DATA_W-1:0]     imm_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_to_reg_e,
  output logic                  mem_write_e,
  output logic                  alu_src_e,
  output logic                  reg_dst_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [REG_ADDR_W-1:0] rs_e,
  output logic [REG_ADDR_W-1:0] rt_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [DATA_W-1:0]     data1_e,
  output logic [DATA_W-1:0]     data2_e,
  output logic [DATA_W-1:0]     imm_e,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // A stall either freezes the stage or turns it into a bubble, fixed at build time.
  localparam bit BUBBLE_MODE = (BUBBLE_ON_STALL != 0);

  id_ex_ctrl_t ctrlD;
  id_ex_ctrl_t ctrlE;
  logic        doBubble;
  logic        doHold;
  logic        stallEvt;

  // Decide this edge's action (flush > stall) and pack the decoded controls.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    doBubble = flush_i | (stall_i & BUBBLE_MODE);
    doHold   = stall_i & ~flush_i & ~BUBBLE_MODE;
    stallEvt = stall_i & ~flush_i;
    ctrlD    = ID_EX_CTRL_NOP;
    ctrlD.reg_write  = reg_write_d;
    ctrlD.mem_to_reg = mem_to_reg_d;
    ctrlD.mem_write  = mem_write_d;
    ctrlD.alu_src    = alu_src_d;
    ctrlD.reg_dst    = reg_dst_d;
    ctrlD.alu_ctrl   = DEF_ALU_CTRL_W'(alu_ctrl_d);
  end

  // Pipeline fields: bubble zeroes everything, hold keeps, otherwise load from ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e <= 1'b0;
      ctrlE   <= ID_EX_CTRL_NOP;
      rs_e    <= '0;
      rt_e    <= '0;
      rd_e    <= '0;
      data1_e <= '0;
      data2_e <= '0;
      imm_e   <= '0;
    end else if (doBubble) begin
      valid_e <= 1'b0;
      ctrlE   <= ID_EX_CTRL_NOP;
      rs_e    <= '0;
      rt_e    <= '0;
      rd_e    <= '0;
      data1_e <= '0;
      data2_e <= '0;
      imm_e   <= '0;
    end else if (!doHold) begin
      valid_e <= valid_d;
      ctrlE   <= ctrlD;
      rs_e    <= rs_d;
      rt_e    <= rt_d;
      rd_e    <= rd_d;
      data1_e <= data1_d;
      data2_e <= data2_d;
      imm_e   <= imm_d;
    end
  end

  // Unpack the registered control word onto the EX-side ports.
  always_comb begin
    reg_write_e  = ctrlE.reg_write;
    mem_to_reg_e = ctrlE.mem_to_reg;
    mem_write_e  = ctrlE.mem_write;
    alu_src_e    = ctrlE.alu_src;
    reg_dst_e    = ctrlE.reg_dst;
    alu_ctrl_e   = ALU_CTRL_W'(ctrlE.alu_ctrl);
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt_i),
    .inc   (stallEvt),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt_i),
    .inc   (doBubble),
    .count (flush_cnt_o)
  );

endmodule
